ram_loader: RTL and testbench

RAM_LOADER -- requirements
Module: ram_loader

---
 rtl/ram_loader_pkg.sv | 16 +
 rtl/ram16k.sv | 24 ++
 rtl/ram_loader.sv | 120 ++++++++++++
 tb/tb_ram_loader.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_loader_pkg.sv
// rtl/ram_loader_pkg.sv - shared state encoding and size defaults for the RAM loader
package ram_loader_pkg;

    localparam int ADDR_W_DEFAULT = 14;
    localparam int DATA_W_DEFAULT = 16;
    localparam int BYTE_W         = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HI   = 3'd1,
        LO   = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } state_e;

endpackage

// File: rtl/ram16k.sv
// rtl/ram16k.sv - word RAM with synchronous write and asynchronous read port
module ram16k #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16
) (
    input  logic              clk_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] address_i,
    input  logic [DATA_W-1:0] in_i,
    output logic [DATA_W-1:0] out_o
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Write the addressed word when load is asserted
    always_ff @(posedge clk_i) begin
        if (load_i) begin
            mem[address_i] <= in_i;
        end
    end

    assign out_o = mem[address_i];

endmodule

// File: rtl/ram_loader.sv
// rtl/ram_loader.sv - assembles a high-byte-first byte stream into RAM word writes
module ram_loader
    import ram_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_address_i,
    input  logic [ADDR_W:0]   length_i,
    input  logic [BYTE_W-1:0] byte_in_i,
    input  logic              byte_valid_i,
    output logic              byte_ready_o,
    output logic [DATA_W-1:0] ram_in_o,
    output logic [ADDR_W-1:0] ram_address_o,
    output logic              ram_load_o,
    output logic              busy_o,
    output logic              done_o
);

    state_e            state_q;
    logic [BYTE_W-1:0] hi_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   len_q;
    logic [DATA_W-1:0] ram_in_q;
    logic [ADDR_W-1:0] ram_address_q;
    logic              ram_load_q;
    logic              done_q;

    logic              byte_fire;
    logic [DATA_W-1:0] word_d;
    logic [ADDR_W:0]   count_d;
    logic [ADDR_W-1:0] addr_d;

    // Ready comes straight from the registered state so reset drops it at once
    assign byte_ready_o = (state_q == HI) || (state_q == LO);
    assign busy_o       = (state_q != IDLE);
    assign byte_fire    = byte_valid_i && byte_ready_o;

    // Next word, next count and next (wrapping) write address
    always_comb begin
        word_d  = DATA_W'({hi_q, byte_in_i});
        count_d = count_q + (ADDR_W + 1)'(1);
        addr_d  = addr_q + ADDR_W'(1);
    end

    // Load sequencer: capture two bytes, issue one write, repeat until length words
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            hi_q          <= '0;
            addr_q        <= '0;
            count_q       <= '0;
            len_q         <= '0;
            ram_in_q      <= '0;
            ram_address_q <= '0;
            ram_load_q    <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        addr_q  <= base_address_i;
                        len_q   <= length_i;
                        count_q <= '0;
                        if (length_i == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= HI;
                        end
                    end
                end
                HI: begin
                    if (byte_fire) begin
                        hi_q    <= byte_in_i;
                        state_q <= LO;
                    end
                end
                LO: begin
                    if (byte_fire) begin
                        ram_in_q      <= word_d;
                        ram_address_q <= addr_q;
                        ram_load_q    <= 1'b1;
                        state_q       <= WR;
                    end
                end
                WR: begin
                    ram_load_q <= 1'b0;
                    addr_q     <= addr_d;
                    count_q    <= count_d;
                    if (count_d == len_q) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= HI;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    ram_load_q <= 1'b0;
                    done_q     <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign ram_in_o      = ram_in_q;
    assign ram_address_o = ram_address_q;
    assign ram_load_o    = ram_load_q;
    assign done_o        = done_q;

endmodule

// File: tb/tb_ram_loader.sv
// tb/tb_ram_loader.sv - table-driven and scoreboarded bench for ram_loader
module tb_ram_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [13:0] base_address = '0;
    logic [14:0] length = '0;
    logic [7:0]  byte_in = '0;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic [15:0] ram_in;
    logic [13:0] ram_address;
    logic        ram_load;
    logic        busy;
    logic        done;

    logic        rd_en = 1'b0;
    logic [13:0] rd_addr = '0;
    logic [13:0] mem_addr;
    logic [15:0] mem_out;

    assign mem_addr = rd_en ? rd_addr : ram_address;

    ram_loader dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .start_i       (start),
        .base_address_i(base_address),
        .length_i      (length),
        .byte_in_i     (byte_in),
        .byte_valid_i  (byte_valid),
        .byte_ready_o  (byte_ready),
        .ram_in_o      (ram_in),
        .ram_address_o (ram_address),
        .ram_load_o    (ram_load),
        .busy_o        (busy),
        .done_o        (done)
    );

    ram16k #(.ADDR_W(14), .DATA_W(16)) u_ram16k (
        .clk_i    (clk),
        .load_i   (ram_load),
        .address_i(mem_addr),
        .in_i     (ram_in),
        .out_o    (mem_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int nload  = 0;
    logic [29:0] exp_q[$];
    logic [7:0]  byte_buf [8];
    bit          use_pattern = 1'b0;

    typedef struct {
        logic [13:0] base;
        logic [14:0] len;
        logic [31:0] bytes;
        bit          toggle;
        int          restart_k;
        int          exp_done_k;
        int          exp_busy;
        logic [15:0] w0;
        logic [15:0] w1;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] pat_word(input int i);
        return 16'(i) ^ 16'hA5C3;
    endfunction

    function automatic logic [7:0] get_byte(input int idx);
        logic [15:0] w;
        if (use_pattern) begin
            w = pat_word(idx / 2);
            return (idx % 2 == 0) ? w[15:8] : w[7:0];
        end
        return byte_buf[idx % 8];
    endfunction

    task automatic read_ram(input logic [13:0] a, output logic [15:0] d);
        rd_en   = 1'b1;
        rd_addr = a;
        #1;
        d     = mem_out;
        rd_en = 1'b0;
    endtask

    // Scoreboard: every RAM write must match the next expected {address, data}
    always @(negedge clk) begin
        if (!reset && ram_load === 1'b1) begin
            nload++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, none expected", ram_address, ram_in);
            end else begin
                check("ram_write", {2'b00, ram_address, ram_in}, {2'b00, exp_q.pop_front()});
            end
        end
    end

    task automatic run_load(input logic [13:0] b, input logic [14:0] len, input int push_n,
                            input bit toggle, input int restart_k, input int stop_k,
                            output int done_k, output int ndone, output int nbusy, output bit finished);
        int idx;
        int nbytes;
        int budget;
        bit fire;
        idx = 0;
        nbytes = 2 * int'(len);
        budget = 8 * int'(len) + 20;
        done_k = -1;
        ndone = 0;
        nbusy = 0;
        finished = 1'b0;
        for (int i = 0; i < push_n; i++) begin
            exp_q.push_back({b + 14'(i), get_byte(2 * i), get_byte(2 * i + 1)});
        end
        @(negedge clk);
        start = 1'b1;
        base_address = b;
        length = len;
        for (int k = 1; k <= budget; k++) begin
            if (k > 1) @(negedge clk);
            if (k == restart_k) begin
                start = 1'b1;
                base_address = 14'h0300;
                length = 15'd1;
            end
            byte_valid = (idx < nbytes) && (toggle ? (k % 2 == 1) : 1'b1);
            byte_in = (idx < nbytes) ? get_byte(idx) : 8'h00;
            fire = byte_valid && byte_ready;
            @(posedge clk);
            #1;
            start = 1'b0;
            if (fire) idx++;
            if (busy) nbusy++;
            if (done) begin
                ndone++;
                if (done_k < 0) done_k = k;
            end
            if (k == stop_k) return;
            if (ndone > 0 && !busy) begin
                finished = 1'b1;
                break;
            end
        end
        byte_valid = 1'b0;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_k, ndone, nbusy, l0, bad, nd;
        bit fin;
        logic [15:0] d;

        vecs[0] = '{14'h0010, 15'd2, 32'h1234ABCD, 1'b0, 0, 7, 7, 16'h1234, 16'hABCD};
        vecs[1] = '{14'h3FFF, 15'd2, 32'h00010002, 1'b0, 0, 7, 7, 16'h0001, 16'h0002};
        vecs[2] = '{14'h0050, 15'd0, 32'h00000000, 1'b0, 0, 1, 1, 16'h0000, 16'h0000};
        vecs[3] = '{14'h0020, 15'd2, 32'h1234ABCD, 1'b1, 0, 10, 10, 16'h1234, 16'hABCD};
        vecs[4] = '{14'h0400, 15'd2, 32'hC0DEBEEF, 1'b0, 3, 7, 7, 16'hC0DE, 16'hBEEF};

        repeat (2) @(posedge clk);
        #1;
        check("reset_byte_ready", byte_ready, 0);
        check("reset_ram_load", ram_load, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_ram_in", ram_in, 0);
        check("reset_ram_address", ram_address, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int r = 0; r < 5; r++) begin
            use_pattern = 1'b0;
            byte_buf[0] = vecs[r].bytes[31:24];
            byte_buf[1] = vecs[r].bytes[23:16];
            byte_buf[2] = vecs[r].bytes[15:8];
            byte_buf[3] = vecs[r].bytes[7:0];
            l0 = nload;
            run_load(vecs[r].base, vecs[r].len, int'(vecs[r].len), vecs[r].toggle,
                     vecs[r].restart_k, 0, done_k, ndone, nbusy, fin);
            check($sformatf("row%0d_finished", r), fin, 1);
            check($sformatf("row%0d_done_count", r), ndone, 1);
            check($sformatf("row%0d_done_cycle", r), done_k, vecs[r].exp_done_k);
            check($sformatf("row%0d_busy_cycles", r), nbusy, vecs[r].exp_busy);
            check($sformatf("row%0d_load_count", r), nload - l0, int'(vecs[r].len));
            check($sformatf("row%0d_sb_empty", r), exp_q.size(), 0);
            if (vecs[r].len >= 1) begin
                read_ram(vecs[r].base, d);
                check($sformatf("row%0d_ram_w0", r), d, vecs[r].w0);
            end
            if (vecs[r].len >= 2) begin
                read_ram(vecs[r].base + 14'd1, d);
                check($sformatf("row%0d_ram_w1", r), d, vecs[r].w1);
            end
            @(negedge clk);
        end

        // Reset between the HI and LO bytes of word 2 of a three-word load
        byte_buf[0] = 8'h11; byte_buf[1] = 8'h22; byte_buf[2] = 8'h33;
        byte_buf[3] = 8'h44; byte_buf[4] = 8'h55; byte_buf[5] = 8'h66;
        l0 = nload;
        run_load(14'h0100, 15'd3, 1, 1'b0, 0, 5, done_k, ndone, nbusy, fin);
        check("rst_pre_ready", byte_ready, 1);
        check("rst_pre_loads", nload - l0, 1);
        #2;
        reset = 1'b1;
        #1;
        check("rst_async_ready", byte_ready, 0);
        check("rst_async_load", ram_load, 0);
        check("rst_async_busy", busy, 0);
        check("rst_async_ram_in", ram_in, 0);
        check("rst_async_ram_addr", ram_address, 0);
        byte_valid = 1'b0;
        nd = ndone;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) nd++;
        end
        check("rst_no_done", nd, 0);
        @(negedge clk);
        reset = 1'b0;
        check("rst_loads_total", nload - l0, 1);
        check("rst_sb_empty", exp_q.size(), 0);
        read_ram(14'h0100, d);
        check("rst_word1_kept", d, 16'h1122);

        byte_buf[0] = 8'h5A; byte_buf[1] = 8'hA5;
        l0 = nload;
        run_load(14'h0200, 15'd1, 1, 1'b0, 0, 0, done_k, ndone, nbusy, fin);
        check("after_rst_finished", fin, 1);
        check("after_rst_done_cycle", done_k, 4);
        check("after_rst_loads", nload - l0, 1);
        read_ram(14'h0200, d);
        check("after_rst_word", d, 16'h5AA5);
        @(negedge clk);

        // Full-depth load starting mid-RAM, crossing the address wrap
        use_pattern = 1'b1;
        l0 = nload;
        run_load(14'h2000, 15'd16384, 16384, 1'b0, 0, 0, done_k, ndone, nbusy, fin);
        check("full_finished", fin, 1);
        check("full_done_count", ndone, 1);
        check("full_load_count", nload - l0, 16384);
        check("full_sb_empty", exp_q.size(), 0);
        bad = 0;
        for (int a = 0; a < 16384; a++) begin
            read_ram(14'(a), d);
            if (d !== pat_word((a - 8192 + 16384) % 16384)) bad++;
        end
        check("full_readback_bad", bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
